// File: rtl/alu_op_driver.sv
// alu_op_driver
//   Initiator for a 4-phase bit-serial ALU. Commands enter a one-entry slot
//   through a valid/ready port. Each command is driven onto alu_a/alu_b/
//   alu_opcode for one phase-aligned 4-cycle window. The ALU outputs are
//   captured one cycle after the window ends and pushed into a small result
//   FIFO that drains through a valid/ready port.
//
// Ports
//   clk, rst                   clock, async active-high reset
//   cmd_valid/ready/op/a/b     command port
//   alu_a/b/opcode             registered drive to the ALU
//   alu_c/carr/sign/zero       ALU results
//   res_valid/ready/c/flags/op result port, flags = {carr, sign, zero}
//   busy                       slot held, window active or capture pending
//
// FSM states
//   state   | meaning
//   ST_IDLE | bus shows IDLE_OP, nothing in the window
//   ST_RUN  | an op is on the bus for the current 4-phase window
module alu_op_driver #(
  parameter int unsigned W         = 4,
  parameter logic [2:0]  IDLE_OP   = 3'b111,
  parameter int unsigned RES_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_opcode,
  input  logic [W-1:0] alu_c,
  input  logic         alu_carr,
  input  logic         alu_sign,
  input  logic         alu_zero,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_c,
  output logic [2:0]   res_flags,
  output logic [2:0]   res_op,
  output logic         busy
);

  localparam int unsigned PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RES_DEPTH + 1);
  localparam int unsigned EW = W + 6;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t          state_q, state_d;
  logic [1:0]      phase_q, phase_d;
  logic            slot_vld_q, slot_vld_d;
  logic [W-1:0]    slot_a_q, slot_a_d;
  logic [W-1:0]    slot_b_q, slot_b_d;
  logic [2:0]      slot_op_q, slot_op_d;
  logic [W-1:0]    alu_a_q, alu_a_d;
  logic [W-1:0]    alu_b_q, alu_b_d;
  logic [2:0]      alu_op_q, alu_op_d;
  logic            cap_q, cap_d;
  logic [2:0]      cap_op_q, cap_op_d;
  logic [EW-1:0]   fifo_q [RES_DEPTH];
  logic [EW-1:0]   fifo_d [RES_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            issue;
  logic            push;
  logic            pop;
  logic [CW:0]     used;

  // A credit covers the op in the window, an op awaiting capture, and every
  // queued result, so a capture can never land on a full FIFO.
  always_comb begin
    used  = (CW+1)'(state_q == ST_RUN) + (CW+1)'(cap_q) + (CW+1)'(cnt_q);
    issue = (phase_q == 2'd3) && slot_vld_q && (used < (CW+1)'(RES_DEPTH));
  end

  // Capture on the edge ending the cycle after the window; this is also the
  // phase-0 edge of a following op, so the ALU outputs are still the old op's.
  assign push      = cap_q && (phase_q == 2'd0);
  assign res_valid = (cnt_q != '0);
  assign pop       = res_valid && res_ready;
  assign cmd_ready = !rst && (!slot_vld_q || issue);

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign {res_c, res_flags, res_op} = fifo_q[rd_ptr_q];
  assign busy = slot_vld_q || (state_q == ST_RUN) || cap_q;

  always_comb begin
    phase_d  = phase_q + 2'd1;
    state_d  = state_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    cap_d    = cap_q && !push;
    cap_op_d = cap_op_q;
    if (phase_q == 2'd3) begin
      if (state_q == ST_RUN) begin
        cap_d    = 1'b1;
        cap_op_d = alu_op_q;
      end
      if (issue) begin
        state_d  = ST_RUN;
        alu_a_d  = slot_a_q;
        alu_b_d  = slot_b_q;
        alu_op_d = slot_op_q;
      end else begin
        state_d  = ST_IDLE;
        alu_a_d  = '0;
        alu_b_d  = '0;
        alu_op_d = IDLE_OP;
      end
    end
  end

  always_comb begin
    slot_vld_d = slot_vld_q;
    slot_a_d   = slot_a_q;
    slot_b_d   = slot_b_q;
    slot_op_d  = slot_op_q;
    if (issue) slot_vld_d = 1'b0;
    if (cmd_valid && cmd_ready) begin
      slot_vld_d = 1'b1;
      slot_a_d   = cmd_a;
      slot_b_d   = cmd_b;
      slot_op_d  = cmd_op;
    end
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      fifo_d[wr_ptr_q] = {alu_c, alu_carr, alu_sign, alu_zero, cap_op_q};
      wr_ptr_d = (wr_ptr_q == PW'(RES_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(RES_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q    <= '0;
      state_q    <= ST_IDLE;
      slot_vld_q <= 1'b0;
      slot_a_q   <= '0;
      slot_b_q   <= '0;
      slot_op_q  <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= IDLE_OP;
      cap_q      <= 1'b0;
      cap_op_q   <= IDLE_OP;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < RES_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      phase_q    <= phase_d;
      state_q    <= state_d;
      slot_vld_q <= slot_vld_d;
      slot_a_q   <= slot_a_d;
      slot_b_q   <= slot_b_d;
      slot_op_q  <= slot_op_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      cap_q      <= cap_d;
      cap_op_q   <= cap_op_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      fifo_q     <= fifo_d;
    end
  end

endmodule

// File: tb/tb_alu_op_driver.sv
module tb_alu_op_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a, cmd_b;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_opcode;
  logic [3:0] alu_c;
  logic       alu_carr, alu_sign, alu_zero;
  logic       res_valid, res_ready;
  logic [3:0] res_c;
  logic [2:0] res_flags, res_op;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  alu_op_driver dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_c(alu_c), .alu_carr(alu_carr), .alu_sign(alu_sign), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready), .res_c(res_c),
    .res_flags(res_flags), .res_op(res_op), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // returns {c, carr, sign, zero}; illegal opcodes leave the ALU unchanged
  function automatic logic [6:0] alu_fn(input logic [2:0] op, input logic [3:0] a,
                                        input logic [3:0] b, input logic [6:0] last);
    logic [4:0] s;
    logic [3:0] c;
    logic       cy;
    s = '0; c = '0; cy = 1'b0;
    case (op)
      3'd0: return 7'b0000_001;
      3'd1: c = ~(a ^ b);
      3'd2: begin s = {1'b0, b} - {1'b0, a}; c = s[3:0]; cy = s[4]; end
      3'd3: c = ~(a & b);
      3'd4: begin s = {1'b0, a} + {1'b0, b}; c = s[3:0]; cy = s[4]; end
      default: return last;
    endcase
    return {c, cy, c[3], (c == 4'h0)};
  endfunction

  // Serial ALU stand-in: own phase counter, results valid from the cycle after phase 3.
  logic [1:0] m_phase = 2'd0;
  logic [6:0] m_out = 7'b0000_001;
  assign {alu_c, alu_carr, alu_sign, alu_zero} = m_out;
  always @(posedge clk or posedge rst) begin
    if (rst) m_phase <= 2'd0;
    else begin
      m_phase <= m_phase + 2'd1;
      if (m_phase == 2'd3) m_out <= alu_fn(alu_opcode, alu_a, alu_b, m_out);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted command yields one result, in order.
  logic [9:0] exp_q[$];
  logic [6:0] ref_last = 7'b0000_001;
  logic [6:0] sb_r;
  always @(negedge clk) begin
    if (!rst) begin
      if (res_valid && res_ready) begin
        chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          chk("sb_result", 32'({res_c, res_flags, res_op}), 32'(exp_q[0]));
          void'(exp_q.pop_front());
        end
      end
      if (cmd_valid && cmd_ready) begin
        sb_r = alu_fn(cmd_op, cmd_a, cmd_b, ref_last);
        ref_last = sb_r;
        exp_q.push_back({sb_r, cmd_op});
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    @(negedge clk);
    while (!cmd_ready && n < 60) begin @(negedge clk); n++; end
    chk("send_accepted", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_op(input string tag, input logic [2:0] op, output int at);
    int n;
    n = 0;
    @(negedge clk);
    while (alu_opcode !== op && n < 40) begin @(negedge clk); n++; end
    chk(tag, 32'(alu_opcode === op), 32'd1);
    at = cyc;
  endtask

  task automatic wait_res(input string tag, output int at);
    int n;
    n = 0;
    @(negedge clk);
    while (res_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk(tag, 32'(res_valid), 32'd1);
    at = cyc;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || res_valid) && n < 100) begin @(negedge clk); n++; end
    chk(tag, 32'(!busy && !res_valid), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, r1, r2, idle_seen, n;
    cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_opcode", 32'(alu_opcode), 32'h7);
    chk("rst_alu_a", 32'(alu_a), 32'h0);
    chk("rst_alu_b", 32'(alu_b), 32'h0);
    chk("rst_res_valid", 32'(res_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    rst = 1'b0;

    // 1: ADD 3+5, latency t0 -> res_valid
    tick();
    send(3'd4, 4'h3, 4'h5);
    wait_op("add_on_bus", 3'd4, t0);
    chk("t0_phase0", 32'(m_phase), 32'd0);
    chk("t0_alu_a", 32'(alu_a), 32'h3);
    chk("t0_alu_b", 32'(alu_b), 32'h5);
    wait_res("add_res", r1);
    chk("add_latency", 32'(r1 - t0), 32'd5);
    chk("add_res_c", 32'(res_c), 32'h8);
    chk("add_flags", 32'(res_flags), 32'b010);
    chk("add_res_op", 32'(res_op), 32'b100);
    tick(); res_ready = 1'b1;

    // 2: ADD F+1 carry, then RESET op
    wait_idle("idle_t2");
    tick(); res_ready = 1'b0;
    send(3'd4, 4'hF, 4'h1);
    send(3'd0, 4'h9, 4'h9);
    wait_res("ovf_res", r1);
    chk("ovf_res_c", 32'(res_c), 32'h0);
    chk("ovf_flags", 32'(res_flags), 32'b101);
    tick(); res_ready = 1'b1;
    tick(); res_ready = 1'b0;
    wait_res("reset_res", r1);
    chk("reset_op", 32'(res_op), 32'b000);
    chk("reset_res_c", 32'(res_c), 32'h0);
    chk("reset_flags", 32'(res_flags), 32'b001);
    tick(); res_ready = 1'b1;

    // 3: back-to-back XNOR then NAND
    wait_idle("idle_t3");
    tick();
    send(3'd1, 4'hA, 4'hA);
    send(3'd3, 4'hF, 4'h0);
    wait_op("xnor_on_bus", 3'd1, t0);
    idle_seen = 0; n = 0;
    while (alu_opcode !== 3'd3 && n < 20) begin
      if (alu_opcode === 3'h7) idle_seen++;
      @(negedge clk); n++;
    end
    t1 = cyc;
    chk("b2b_no_idle", 32'(idle_seen), 32'd0);
    chk("b2b_spacing", 32'(t1 - t0), 32'd4);
    wait_res("xnor_res", r1);
    chk("xnor_res_c", 32'(res_c), 32'hF);
    chk("xnor_res_op", 32'(res_op), 32'd1);
    wait_res("nand_res", r2);
    chk("nand_res_c", 32'(res_c), 32'hF);
    chk("nand_res_op", 32'(res_op), 32'd3);
    chk("b2b_res_gap", 32'(r2 - r1), 32'd4);

    // 4: credit stall with res_ready low
    wait_idle("idle_t4");
    tick(); res_ready = 1'b0;
    send(3'd4, 4'h1, 4'h2);
    send(3'd2, 4'h3, 4'h9);
    send(3'd3, 4'h5, 4'h6);
    repeat (12) @(negedge clk);
    chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("stall_res_valid", 32'(res_valid), 32'd1);
    chk("stall_not_issued", 32'(alu_opcode), 32'h7);
    chk("stall_busy", 32'(busy), 32'd1);
    chk("stall_head_op", 32'(res_op), 32'd4);
    repeat (4) @(negedge clk);
    chk("stall_head_held", 32'({res_c, res_flags}), 32'({4'h3, 3'b000}));
    tick(); res_ready = 1'b1;
    wait_op("stall_third_issue", 3'd3, t0);
    chk("stall_third_phase", 32'(m_phase), 32'd0);

    // 5: reset during phase 2 of a SUB
    wait_idle("idle_t5");
    tick();
    send(3'd2, 4'h2, 4'h7);
    wait_op("sub_on_bus", 3'd2, t0);
    @(posedge clk);
    @(posedge clk); #2;
    chk("sub_phase2", 32'(m_phase), 32'd2);
    rst = 1'b1;
    exp_q.delete();
    ref_last = m_out;
    #1;
    chk("midrst_opcode", 32'(alu_opcode), 32'h7);
    chk("midrst_res_valid", 32'(res_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("postrst_no_stale", 32'(res_valid), 32'd0);
    chk("postrst_idle_op", 32'(alu_opcode), 32'h7);

    // 6: command arriving mid-window
    tick();
    send(3'd4, 4'h6, 4'h7);
    wait_op("win_on_bus", 3'd4, t0);
    tick();
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_a = 4'h9; cmd_b = 4'h3;
    @(negedge clk);
    chk("mid_ready", 32'(cmd_ready), 32'd1);
    tick(); cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_hold_t2", 32'({alu_opcode, alu_a, alu_b}), 32'({3'd4, 4'h6, 4'h7}));
    @(negedge clk);
    chk("mid_hold_t3", 32'({alu_opcode, alu_a, alu_b}), 32'({3'd4, 4'h6, 4'h7}));
    @(negedge clk);
    chk("mid_next_op", 32'({alu_opcode, alu_a, alu_b}), 32'({3'd1, 4'h9, 4'h3}));

    // random traffic, illegal opcodes included
    for (int i = 0; i < 300; i++) begin
      tick();
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 3'($urandom_range(0, 7));
      cmd_a     = 4'($urandom);
      cmd_b     = 4'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
    end
    tick();
    cmd_valid = 1'b0; res_ready = 1'b1;
    wait_idle("idle_drain");
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
